// File: rtl/mr_pkg.sv
// Shared encodings for the Maquina Rudimentaria control path.
package mr_pkg;

  typedef enum logic [1:0] {
    CLS_LOAD   = 2'b00,
    CLS_STORE  = 2'b01,
    CLS_ALU    = 2'b10,
    CLS_BRANCH = 2'b11
  } op_class_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_ASR = 2'b10,
    ALU_AND = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH       = 3'd0,
    S_DECODE      = 3'd1,
    S_EXEC_LOAD   = 3'd2,
    S_EXEC_STORE  = 3'd3,
    S_EXEC_ALU    = 3'd4,
    S_EXEC_BRANCH = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'b000,
    COND_Z      = 3'b001,
    COND_N      = 3'b010,
    COND_NZ     = 3'b011,
    COND_NEVER  = 3'b100,
    COND_NOT_Z  = 3'b101,
    COND_NOT_N  = 3'b110,
    COND_NOT_NZ = 3'b111
  } cond_t;

endpackage

// File: rtl/mr_control_unit_if.sv
// Control-unit <-> datapath signal bundle; master is the control unit.
interface mr_control_unit_if #(
    parameter int N = 16
) ();
    logic [N-1:0] ir;
    logic         mem_ready;
    logic         alu_z;
    logic         alu_n;
    logic         ld_ir;
    logic         ld_pc;
    logic         pc_sel;
    logic         addr_sel;
    logic         mem_we;
    logic         ld_reg;
    logic         reg_src;
    logic [1:0]   alu_op;
    logic         alu_operar;
    logic         alu_imm;
    logic         ld_flags;
    logic         flag_z;
    logic         flag_n;
    logic [2:0]   state;

    modport master (
        input  ir, mem_ready, alu_z, alu_n,
        output ld_ir, ld_pc, pc_sel, addr_sel, mem_we, ld_reg, reg_src,
               alu_op, alu_operar, alu_imm, ld_flags, flag_z, flag_n, state
    );

    modport slave (
        output ir, mem_ready, alu_z, alu_n,
        input  ld_ir, ld_pc, pc_sel, addr_sel, mem_we, ld_reg, reg_src,
               alu_op, alu_operar, alu_imm, ld_flags, flag_z, flag_n, state
    );
endinterface

// File: rtl/mr_branch_eval.sv
// Branch condition decode against the registered Z/N flags.
module mr_branch_eval
    import mr_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond))
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flag_z;
            COND_N:      taken = flag_n;
            COND_NZ:     taken = flag_n | flag_z;
            COND_NEVER:  taken = 1'b0;
            COND_NOT_Z:  taken = ~flag_z;
            COND_NOT_N:  taken = ~flag_n;
            COND_NOT_NZ: taken = ~(flag_n | flag_z);
            default:     taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/mr_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer with registered Z/N flags.
module mr_control_unit
    import mr_pkg::*;
#(
    parameter int N = 16
) (
    input logic clk,
    input logic rst,
    mr_control_unit_if.master bus
);
    localparam int CLS_HI  = N - 1;
    localparam int COND_HI = N - 3;

    state_t     state_q;
    logic       flag_z_q;
    logic       flag_n_q;
    logic       taken;

    logic       ld_ir;
    logic       ld_pc;
    logic       pc_sel;
    logic       addr_sel;
    logic       mem_we;
    logic       ld_reg;
    logic       reg_src;
    logic [1:0] alu_op;
    logic       alu_operar;
    logic       alu_imm;
    logic       ld_flags;

    mr_branch_eval u_branch_eval (
        .cond   (bus.ir[COND_HI -: 3]),
        .flag_z (flag_z_q),
        .flag_n (flag_n_q),
        .taken  (taken)
    );

    // Strobes are gated by rst so an aborted instruction has no side effects.
    always_comb begin
        ld_ir      = 1'b0;
        ld_pc      = 1'b0;
        pc_sel     = 1'b0;
        addr_sel   = 1'b0;
        mem_we     = 1'b0;
        ld_reg     = 1'b0;
        reg_src    = 1'b0;
        alu_op     = ALU_ADD;
        alu_operar = 1'b0;
        alu_imm    = 1'b0;
        ld_flags   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ld_ir = 1'b1;
                        ld_pc = 1'b1;
                    end
                end
                S_EXEC_LOAD: begin
                    addr_sel = 1'b1;
                    if (bus.mem_ready) begin
                        ld_reg     = 1'b1;
                        reg_src    = 1'b1;
                        alu_operar = 1'b1;
                        alu_op     = ALU_ADD;
                        ld_flags   = 1'b1;
                    end
                end
                S_EXEC_STORE: begin
                    addr_sel = 1'b1;
                    mem_we   = 1'b1;
                end
                S_EXEC_ALU: begin
                    alu_operar = 1'b1;
                    alu_op     = bus.ir[1:0];
                    alu_imm    = bus.ir[2];
                    ld_reg     = 1'b1;
                    ld_flags   = 1'b1;
                end
                S_EXEC_BRANCH: begin
                    if (taken) begin
                        ld_pc  = 1'b1;
                        pc_sel = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            if (ld_flags) begin
                flag_z_q <= bus.alu_z;
                flag_n_q <= bus.alu_n;
            end
            case (state_q)
                S_FETCH: if (bus.mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op_class_t'(bus.ir[CLS_HI -: 2]))
                        CLS_LOAD:   state_q <= S_EXEC_LOAD;
                        CLS_STORE:  state_q <= S_EXEC_STORE;
                        CLS_ALU:    state_q <= S_EXEC_ALU;
                        CLS_BRANCH: state_q <= S_EXEC_BRANCH;
                        default:    state_q <= S_FETCH;
                    endcase
                end
                S_EXEC_LOAD,
                S_EXEC_STORE: if (bus.mem_ready) state_q <= S_FETCH;
                S_EXEC_ALU,
                S_EXEC_BRANCH: state_q <= S_FETCH;
                default:       state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.ld_ir      = ld_ir;
    assign bus.ld_pc      = ld_pc;
    assign bus.pc_sel     = pc_sel;
    assign bus.addr_sel   = addr_sel;
    assign bus.mem_we     = mem_we;
    assign bus.ld_reg     = ld_reg;
    assign bus.reg_src    = reg_src;
    assign bus.alu_op     = alu_op;
    assign bus.alu_operar = alu_operar;
    assign bus.alu_imm    = alu_imm;
    assign bus.ld_flags   = ld_flags;
    assign bus.flag_z     = flag_z_q;
    assign bus.flag_n     = flag_n_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mr_control_unit.sv
// Directed-vector scoreboard bench for mr_control_unit.
module tb_mr_control_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mr_control_unit_if #(.N(16)) bus ();

    mr_control_unit #(.N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       ld_ir;
        logic       ld_pc;
        logic       pc_sel;
        logic       addr_sel;
        logic       mem_we;
        logic       ld_reg;
        logic       reg_src;
        logic [1:0] alu_op;
        logic       alu_operar;
        logic       alu_imm;
        logic       ld_flags;
        logic       flag_z;
        logic       flag_n;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    sb_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Strobe groups: {ld_ir, ld_pc, pc_sel, addr_sel, mem_we, ld_reg, reg_src}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] FET  = 7'b1100000;
    localparam logic [6:0] BR   = 7'b0110000;
    localparam logic [6:0] ALUW = 7'b0000010;
    localparam logic [6:0] LDW  = 7'b0001000;
    localparam logic [6:0] LDC  = 7'b0001011;
    localparam logic [6:0] STW  = 7'b0001100;
    // {alu_operar, alu_imm, ld_flags}
    localparam logic [2:0] A0   = 3'b000;
    localparam logic [2:0] AALU = 3'b101;
    localparam logic [2:0] AIMM = 3'b111;

    function automatic out_t e(input logic [2:0] st, input logic [6:0] s,
                               input logic [1:0] op, input logic [2:0] a,
                               input logic [1:0] fl);
        return out_t'({st, s, op, a, fl});
    endfunction

    task automatic cyc(input string nm, input logic r, input logic [15:0] i,
                       input logic m, input logic z, input logic n, input out_t ex);
        sb_t item;
        @(posedge clk);
        #1;
        rst           = r;
        bus.ir        = i;
        bus.mem_ready = m;
        bus.alu_z     = z;
        bus.alu_n     = n;
        item.name     = nm;
        item.exp      = ex;
        q.push_back(item);
    endtask

    // Monitor: every cycle the DUT presents a full output set, checked mid-cycle.
    initial begin
        sb_t  item;
        out_t act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                item = q.pop_front();
                act = {bus.state, bus.ld_ir, bus.ld_pc, bus.pc_sel, bus.addr_sel,
                       bus.mem_we, bus.ld_reg, bus.reg_src, bus.alu_op,
                       bus.alu_operar, bus.alu_imm, bus.ld_flags,
                       bus.flag_z, bus.flag_n};
                n_checks++;
                if (act !== item.exp) begin
                    n_fail++;
                    $display("FAIL %s: actual=%b required=%b", item.name, act, item.exp);
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.ir        = '0;
        bus.mem_ready = 1'b0;
        bus.alu_z     = 1'b0;
        bus.alu_n     = 1'b0;

        cyc("rst0",          1, 16'h8000, 1, 0, 0, e(3'd0, NONE, 2'b00, A0,   2'b00));
        cyc("rst1",          1, 16'h8000, 1, 0, 0, e(3'd0, NONE, 2'b00, A0,   2'b00));
        cyc("add_fetch",     0, 16'h8000, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b00));
        cyc("add_decode",    0, 16'h8000, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b00));
        cyc("add_exec",      0, 16'h8000, 1, 0, 0, e(3'd4, ALUW, 2'b00, AALU, 2'b00));
        cyc("sub_fetch",     0, 16'h8001, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b00));
        cyc("sub_decode",    0, 16'h8001, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b00));
        cyc("sub_exec",      0, 16'h8001, 1, 1, 0, e(3'd4, ALUW, 2'b01, AALU, 2'b00));
        cyc("beq_t_fetch",   0, 16'hC80A, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b10));
        cyc("beq_t_decode",  0, 16'hC80A, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b10));
        cyc("beq_taken",     0, 16'hC80A, 1, 0, 0, e(3'd5, BR,   2'b00, A0,   2'b10));
        cyc("asr_fetch",     0, 16'h8006, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b10));
        cyc("asr_decode",    0, 16'h8006, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b10));
        cyc("asr_imm_exec",  0, 16'h8006, 1, 0, 1, e(3'd4, ALUW, 2'b10, AIMM, 2'b10));
        cyc("beq_nt_fetch",  0, 16'hC80A, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b01));
        cyc("beq_nt_decode", 0, 16'hC80A, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b01));
        cyc("beq_not_taken", 0, 16'hC80A, 1, 0, 0, e(3'd5, NONE, 2'b00, A0,   2'b01));
        cyc("bn_fetch",      0, 16'hD005, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b01));
        cyc("bn_decode",     0, 16'hD005, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b01));
        cyc("bn_taken",      0, 16'hD005, 1, 0, 0, e(3'd5, BR,   2'b00, A0,   2'b01));
        cyc("nop_fetch",     0, 16'hE000, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b01));
        cyc("nop_decode",    0, 16'hE000, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b01));
        cyc("nop_exec",      0, 16'hE000, 1, 0, 0, e(3'd5, NONE, 2'b00, A0,   2'b01));
        cyc("ld_fetch",      0, 16'h0000, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b01));
        cyc("ld_decode",     0, 16'h0000, 0, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b01));
        cyc("ld_wait0",      0, 16'h0000, 0, 0, 0, e(3'd2, LDW,  2'b00, A0,   2'b01));
        cyc("ld_wait1",      0, 16'h0000, 0, 0, 0, e(3'd2, LDW,  2'b00, A0,   2'b01));
        cyc("ld_wait2",      0, 16'h0000, 0, 0, 0, e(3'd2, LDW,  2'b00, A0,   2'b01));
        cyc("ld_done",       0, 16'h0000, 1, 1, 0, e(3'd2, LDC,  2'b00, AALU, 2'b01));
        cyc("st_fetch_wait", 0, 16'h4000, 0, 0, 0, e(3'd0, NONE, 2'b00, A0,   2'b10));
        cyc("st_fetch",      0, 16'h4000, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b10));
        cyc("st_decode",     0, 16'h4000, 1, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b10));
        cyc("st_exec",       0, 16'h4000, 1, 0, 1, e(3'd3, STW,  2'b00, A0,   2'b10));
        cyc("st2_fetch",     0, 16'h4000, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b10));
        cyc("st2_decode",    0, 16'h4000, 0, 0, 0, e(3'd1, NONE, 2'b00, A0,   2'b10));
        cyc("st2_rst_abort", 1, 16'h4000, 0, 0, 0, e(3'd3, NONE, 2'b00, A0,   2'b10));
        cyc("post_rst",      0, 16'h8000, 1, 0, 0, e(3'd0, FET,  2'b00, A0,   2'b00));

        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual=%0d pending required=0 pending", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
